scroll_sequencer: RTL
=====================

Name: scroll_sequencer

Overview:
Sequencer for the 8-digit rotating HEX display. It generates the 3-bit rotation position that selects the character assignment for each display mux. It replaces the free-running 1 s pulse counter with a controlled scroller that supports:
- start/restart
- pause
- direction control
- 4 speed settings
- continuous or single-pass (one-shot) scrolling with a completion flag
It is driven from the board's 50 MHz clock and the toggle switches / pushbutton.

Parameters:
TICKS_PER_STEP, 50_000_000, base clock cycles per position step at Speed=0; must be ≥ 8.
NUM_POS, 8, number of rotation positions; legal range 2..8; Position wraps NUM_POS-1 ↔ 0.

Ports:
CLOCK_50  input  1  system clock; all logic on the rising edge.
Clear     input  1  synchronous, active-high reset; highest priority.
Enable    input  1  1 = scroll runs; 0 = pause (prescaler and Position frozen).
Start     input  1  level input; rising edge starts or restarts a scroll.
Dir       input  1  0 = Position increments, 1 = Position decrements.
Speed     input  2  step period = TICKS_PER_STEP >> Speed (1x, 2x, 4x, 8x faster).
OneShot   input  1  1 = stop after one full pass of NUM_POS steps; 0 = scroll continuously.
Position  output 3  current rotation index, 0..NUM_POS-1; registered.
Step      output 1  one-cycle pulse, high in exactly the cycle Position takes a new value.
Busy      output 1  1 while in state RUN.
Done      output 1  1 while in state DONE.

Behaviour:
- Reset (Clear=1 at a clock edge):
  - state=IDLE, Position=0, Step=0, Busy=0, Done=0, prescaler=0, step count=0.
  - start_q=1, so a Start held high through reset does not trigger; Start must be seen low first.
  - Clear mid-run aborts immediately, with the same values.
- Start edge detect: start_edge = Start & ~start_q; start_q <= Start every cycle.
- Prescaler:
  - Counter width = clog2(TICKS_PER_STEP).
  - term = (TICKS_PER_STEP >> Speed) - 1.
  - Counts only in RUN with Enable=1.
  - When cnt >= term: tick, and cnt <= 0. Otherwise cnt <= cnt+1.
  - The >= comparison covers a Speed change mid-count: if the new term is below cnt, the tick fires on the next enabled cycle.
- State IDLE:
  - Position held, Busy=0, Done=0.
  - start_edge → RUN, Position<=0, cnt<=0, step count<=0.
  - Enable is not required to leave IDLE.
- State RUN:
  - Busy=1.
  - On tick: Position <= Position±1 per current Dir, modulo NUM_POS. Increment wraps NUM_POS-1→0; decrement wraps 0→NUM_POS-1.
  - Step=1 in the same cycle the new Position is visible.
  - Step count increments on each tick.
  - Enable=0 → hold everything. No tick, no Step. State stays RUN and Busy stays 1.
  - start_edge in RUN → restart: Position<=0, cnt<=0, step count<=0. No Step pulse. A simultaneous tick is discarded.
  - OneShot=1 and the tick that makes step count reach NUM_POS → after that step, DONE. That final step still produces Position and Step.
  - OneShot sampled on each tick. Clearing it mid-pass makes the scroll continuous. Setting it mid-pass ends the scroll when step count reaches NUM_POS; the step count saturates at NUM_POS.
  - Dir change mid-run applies from the next tick. Steps are counted regardless of direction.
- State DONE:
  - Done=1, Busy=0, Position held.
  - start_edge → RUN, with the same initialisation as from IDLE.
- Latency:
  - Start edge sampled at edge N → Busy=1, Position=0 after edge N.
  - First Step/Position change occurs TICKS_PER_STEP>>Speed enabled cycles later.
  - Enabled steps are exactly period = TICKS_PER_STEP>>Speed cycles apart.
- Step is low in every cycle except the tick-update cycle, and always low outside RUN.
- Position never leaves 0..NUM_POS-1.

Test Plan:
Bench uses TICKS_PER_STEP=8, NUM_POS=8.
1. Reset, then Start pulse, Enable=1, Dir=0, Speed=0, OneShot=0 → Busy=1. Position steps 0,1,...,7,0,1 with Step pulses exactly 8 cycles apart. Done stays 0.
2. Speed=2 (period 2) with OneShot=1 → 8 steps 2 cycles apart, ending Position=0. Done=1 and Busy=0 in the cycle after the 8th Step. A further Start edge restarts with Busy=1, Done=0.
3. Dir=1 from Position=0 → next Step gives Position=7, then 6. Flip Dir=0 mid-period → next Step returns to 7.
4. Enable=0 for 20 cycles mid-period after 3 counts → no Step, Position frozen. After Enable=1, the Step arrives 5 enabled cycles later.
5. Start edge arrives in the same cycle a tick is due, Position=5 → Position=0, no Step that cycle. The next Step is 8 cycles later with Position=1.
6. Hold Start=1 across Clear and release Clear → stays IDLE. Assert Clear mid-run at Position=4 → all outputs 0, IDLE on the next edge.

Source files
------------

// File: rtl/scroll_sequencer_if.sv
// Control and status bundle between the scroll sequencer and its driver
// (switches/pushbutton side as master, sequencer as slave).
interface scroll_sequencer_if;
  logic       Enable;
  logic       Start;
  logic       Dir;
  logic [1:0] Speed;
  logic       OneShot;
  logic [2:0] Position;
  logic       Step;
  logic       Busy;
  logic       Done;

  modport master (
    output Enable, Start, Dir, Speed, OneShot,
    input  Position, Step, Busy, Done
  );

  modport slave (
    input  Enable, Start, Dir, Speed, OneShot,
    output Position, Step, Busy, Done
  );
endinterface

// File: rtl/scroll_sequencer.sv
// Rotation-position sequencer for the 8-digit scrolling HEX display:
// start/restart, pause, direction, 4 speeds and one-shot mode with completion flag.
module scroll_sequencer #(
  parameter int TICKS_PER_STEP = 50_000_000,
  parameter int NUM_POS        = 8
) (
  input  logic CLOCK_50,
  input  logic Clear,
  scroll_sequencer_if.slave bus
);

  localparam int          CW      = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [31:0] TPS     = 32'(TICKS_PER_STEP);
  localparam logic [2:0]  POS_MAX = 3'(NUM_POS - 1);
  localparam logic [3:0]  NPOS    = 4'(NUM_POS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      pos_q, pos_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      scnt_q, scnt_d;
  logic            step_q, step_d;
  logic            busy_q, done_q;
  logic            start_q;

  logic            start_edge_s;
  logic [CW-1:0]   term_s;
  logic            tick_s;
  logic [2:0]      pos_adv_s;
  logic [3:0]      scnt_inc_s;

  // Prescaler terminal value, wrap-around position step and saturating step count
  always_comb begin
    start_edge_s = bus.Start & ~start_q;
    term_s       = CW'((TPS >> bus.Speed) - 32'd1);
    tick_s       = (cnt_q >= term_s);
    if (bus.Dir) begin
      pos_adv_s = (pos_q == 3'd0) ? POS_MAX : (pos_q - 3'd1);
    end else begin
      pos_adv_s = (pos_q == POS_MAX) ? 3'd0 : (pos_q + 3'd1);
    end
    scnt_inc_s = (scnt_q >= NPOS) ? NPOS : (scnt_q + 4'd1);
  end

  // Next-state logic; a start edge always (re)initialises the scroll and wins over a tick
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge_s) begin
          state_d = S_RUN;
          pos_d   = 3'd0;
          cnt_d   = '0;
          scnt_d  = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (start_edge_s) begin
          pos_d  = 3'd0;
          cnt_d  = '0;
          scnt_d = 4'd0;
        end else if (bus.Enable && tick_s) begin
          cnt_d  = '0;
          pos_d  = pos_adv_s;
          step_d = 1'b1;
          scnt_d = scnt_inc_s;
          if (bus.OneShot && (scnt_inc_s >= NPOS)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else if (bus.Enable) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        pos_d   = 3'd0;
        cnt_d   = '0;
        scnt_d  = 4'd0;
      end
    endcase
  end

  // State and output registers; Clear arms start_q so a held Start cannot trigger
  always_ff @(posedge CLOCK_50) begin
    if (Clear) begin
      state_q <= S_IDLE;
      pos_q   <= 3'd0;
      cnt_q   <= '0;
      scnt_q  <= 4'd0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      step_q  <= step_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
      start_q <= bus.Start;
    end
  end

  assign bus.Position = pos_q;
  assign bus.Step     = step_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule
